// File: rtl/access_ctrl_pkg.sv
// Shared types for the door-access controller: FSM states and the
// per-state output encoding driven onto the LEDs / door / alarm pins.
package access_ctrl_pkg;

  typedef enum logic [2:0] {
    S_SETUP,
    S_IDLE,
    S_ADMIN,
    S_ADD,
    S_DEL,
    S_GRANT,
    S_DENY,
    S_LOCKOUT
  } state_t;

  // Registered output bundle; ready is the id_ready handshake output.
  typedef struct packed {
    logic red;
    logic blue;
    logic green;
    logic unlock;
    logic alarm;
    logic ready;
  } out_t;

  localparam out_t OUT_SETUP   = 6'b00000_1;
  localparam out_t OUT_IDLE    = 6'b01000_1;
  localparam out_t OUT_ADMIN   = 6'b01100_1;
  localparam out_t OUT_UPDATE  = 6'b11100_0;
  localparam out_t OUT_GRANT   = 6'b00110_0;
  localparam out_t OUT_DENY    = 6'b10000_0;
  localparam out_t OUT_LOCKOUT = 6'b10001_0;

  function automatic out_t state_out(input state_t s);
    case (s)
      S_SETUP:   return OUT_SETUP;
      S_IDLE:    return OUT_IDLE;
      S_ADMIN:   return OUT_ADMIN;
      S_ADD,
      S_DEL:     return OUT_UPDATE;
      S_GRANT:   return OUT_GRANT;
      S_DENY:    return OUT_DENY;
      S_LOCKOUT: return OUT_LOCKOUT;
      default:   return OUT_SETUP;
    endcase
  endfunction

endpackage

// File: rtl/access_ctrl_table_id_table.sv
// User ID table: DEPTH entries, parallel match against valid entries,
// append at user_count and delete with order-preserving compaction.
module id_table
  import access_ctrl_pkg::*;
#(
  parameter int ID_W  = 32,
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH + 1),
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [ID_W-1:0]  lookup_id,
  output logic             hit,
  output logic [IDX_W-1:0] hit_idx,
  input  logic             add_en,
  input  logic [ID_W-1:0]  add_id,
  input  logic             del_en,
  input  logic [IDX_W-1:0] del_idx,
  output logic [CNT_W-1:0] user_count,
  output logic             full
);

  logic [ID_W-1:0] entries [DEPTH];

  // Parallel compare; entries at or above user_count are stale and ignored.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if ((CNT_W'(i) < user_count) && (entries[i] == lookup_id)) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  // Storage update: append at the tail, or shift everything above del_idx down.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
      user_count <= '0;
      full       <= 1'b0;
    end else if (add_en) begin
      entries[user_count[IDX_W-1:0]] <= add_id;
      user_count <= user_count + 1'b1;
      full       <= (user_count == CNT_W'(DEPTH - 1));
    end else if (del_en) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        if (IDX_W'(i) >= del_idx) entries[i] <= entries[i+1];
      end
      user_count <= user_count - 1'b1;
      full       <= 1'b0;
    end
  end

endmodule

// File: rtl/access_ctrl_table.sv
// Door-access controller: admin enrolment, admin-mode table edits,
// user-mode grant/deny windows and a fail-count driven lockout.
//
// Handshake: an ID transfers on a rising edge where id_valid && id_ready.
// id_ready is registered and high only in SETUP, IDLE and ADMIN; id_valid
// seen in any other state is dropped, never queued.
module access_ctrl_table
  import access_ctrl_pkg::*;
#(
  parameter int ID_W           = 32,
  parameter int DEPTH          = 8,
  parameter int UNLOCK_CYCLES  = 16,
  parameter int MAX_FAIL       = 3,
  parameter int LOCKOUT_CYCLES = 64,
  parameter int CNT_W          = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [ID_W-1:0]  id,
  output logic             id_ready,
  output logic             red_led,
  output logic             blue_led,
  output logic             green_led,
  output logic             unlock,
  output logic             alarm,
  output logic             err,
  output logic [CNT_W-1:0] user_count,
  output logic             full,
  output state_t           state_dbg
);

  localparam int IDX_W   = $clog2(DEPTH);
  localparam int MAX_DUR = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int DUR_W   = $clog2(MAX_DUR + 1);
  localparam int FAIL_W  = $clog2(MAX_FAIL + 1);

  state_t            state;
  out_t              outs;
  logic [ID_W-1:0]   admin_id;
  logic [ID_W-1:0]   cap_id;
  logic [IDX_W-1:0]  cap_idx;
  logic [DUR_W-1:0]  dur;
  logic [FAIL_W-1:0] fail_cnt;
  logic              hit;
  logic [IDX_W-1:0]  hit_idx;

  id_table #(
    .ID_W  (ID_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W),
    .IDX_W (IDX_W)
  ) u_table (
    .clk        (clk),
    .rst_n      (rst_n),
    .lookup_id  (id),
    .hit        (hit),
    .hit_idx    (hit_idx),
    .add_en     (state == S_ADD),
    .add_id     (cap_id),
    .del_en     (state == S_DEL),
    .del_idx    (cap_idx),
    .user_count (user_count),
    .full       (full)
  );

  // Main FSM; outputs are registered alongside the state they belong to.
  // The denial that reaches MAX_FAIL goes straight to LOCKOUT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_SETUP;
      outs     <= state_out(S_SETUP);
      err      <= 1'b0;
      admin_id <= '0;
      cap_id   <= '0;
      cap_idx  <= '0;
      dur      <= '0;
      fail_cnt <= '0;
    end else begin
      err <= 1'b0;
      case (state)
        S_SETUP: if (id_valid) begin
          if (id != '0) begin
            admin_id <= id;
            state    <= S_IDLE;
            outs     <= state_out(S_IDLE);
          end else begin
            err <= 1'b1;
          end
        end
        S_IDLE: if (id_valid) begin
          if (id == admin_id) begin
            state <= S_ADMIN;
            outs  <= state_out(S_ADMIN);
          end else if (hit) begin
            fail_cnt <= '0;
            dur      <= DUR_W'(UNLOCK_CYCLES - 1);
            state    <= S_GRANT;
            outs     <= state_out(S_GRANT);
          end else if (fail_cnt == FAIL_W'(MAX_FAIL - 1)) begin
            fail_cnt <= '0;
            dur      <= DUR_W'(LOCKOUT_CYCLES - 1);
            state    <= S_LOCKOUT;
            outs     <= state_out(S_LOCKOUT);
          end else begin
            fail_cnt <= fail_cnt + 1'b1;
            dur      <= DUR_W'(UNLOCK_CYCLES - 1);
            state    <= S_DENY;
            outs     <= state_out(S_DENY);
          end
        end
        S_ADMIN: if (id_valid) begin
          if (id == admin_id) begin
            state <= S_IDLE;
            outs  <= state_out(S_IDLE);
          end else if (id == '0) begin
            err <= 1'b1;
          end else if (hit) begin
            cap_idx <= hit_idx;
            state   <= S_DEL;
            outs    <= state_out(S_DEL);
          end else if (full) begin
            err <= 1'b1;
          end else begin
            cap_id <= id;
            state  <= S_ADD;
            outs   <= state_out(S_ADD);
          end
        end
        S_ADD, S_DEL: begin
          state <= S_ADMIN;
          outs  <= state_out(S_ADMIN);
        end
        default: begin
          if (dur == '0) begin
            state <= S_IDLE;
            outs  <= state_out(S_IDLE);
          end else begin
            dur <= dur - 1'b1;
          end
        end
      endcase
    end
  end

  assign id_ready  = outs.ready;
  assign red_led   = outs.red;
  assign blue_led  = outs.blue;
  assign green_led = outs.green;
  assign unlock    = outs.unlock;
  assign alarm     = outs.alarm;
  assign state_dbg = state;

endmodule

// File: tb/tb_access_ctrl_table.sv
// Bench for access_ctrl_table: directed vector table, hand-written window
// sequences and a randomized run against a queue-based reference model.
module tb_access_ctrl_table;
  import access_ctrl_pkg::*;

  localparam int ID_W = 32;
  localparam int DEPTH = 8;
  localparam int UNLOCK_C = 16;
  localparam int MAX_FAIL = 3;
  localparam int LOCK_C = 64;
  localparam int CNT_W = $clog2(DEPTH + 1);

  // reference model phases
  localparam int P_SETUP = 0, P_IDLE = 1, P_ADMIN = 2, P_UPD = 3,
                 P_GRANT = 4, P_DENY = 5, P_LOCK = 6;

  localparam logic [11:0] RESET_VEC = 12'b00000_0_1_0_0000;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic id_valid = 1'b0;
  logic [ID_W-1:0] id = '0;
  logic id_ready, red_led, blue_led, green_led, unlock, alarm, err, full;
  logic [CNT_W-1:0] user_count;
  state_t state_dbg;

  always #5 clk = ~clk;

  access_ctrl_table #(
    .ID_W(ID_W), .DEPTH(DEPTH), .UNLOCK_CYCLES(UNLOCK_C),
    .MAX_FAIL(MAX_FAIL), .LOCKOUT_CYCLES(LOCK_C)
  ) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id(id),
    .id_ready(id_ready), .red_led(red_led), .blue_led(blue_led),
    .green_led(green_led), .unlock(unlock), .alarm(alarm), .err(err),
    .user_count(user_count), .full(full), .state_dbg(state_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // {red,blue,green,unlock,alarm, err, id_ready, full, user_count}
  function automatic logic [11:0] dut_vec();
    return {red_led, blue_led, green_led, unlock, alarm, err, id_ready, full, user_count};
  endfunction

  // ---------------- reference model ----------------
  int m_phase, m_left, m_fails, m_pend_idx;
  bit m_err, m_pend_del;
  logic [ID_W-1:0] m_admin, m_pend_id;
  logic [ID_W-1:0] m_q[$];

  function automatic int find(input logic [ID_W-1:0] x);
    int r = -1;
    for (int i = 0; i < m_q.size(); i++) if (r < 0 && m_q[i] == x) r = i;
    return r;
  endfunction

  task automatic model_reset();
    m_phase = P_SETUP; m_left = 0; m_fails = 0; m_err = 0;
    m_admin = '0; m_q.delete();
  endtask

  task automatic model_step(input bit v, input logic [ID_W-1:0] x);
    int idx;
    m_err = 0;
    idx = find(x);
    case (m_phase)
      P_SETUP: if (v) begin
        if (x != 0) begin m_admin = x; m_phase = P_IDLE; end
        else m_err = 1;
      end
      P_IDLE: if (v) begin
        if (x == m_admin) m_phase = P_ADMIN;
        else if (idx >= 0) begin m_fails = 0; m_phase = P_GRANT; m_left = UNLOCK_C; end
        else begin
          m_fails++;
          if (m_fails == MAX_FAIL) begin m_fails = 0; m_phase = P_LOCK; m_left = LOCK_C; end
          else begin m_phase = P_DENY; m_left = UNLOCK_C; end
        end
      end
      P_ADMIN: if (v) begin
        if (x == m_admin) m_phase = P_IDLE;
        else if (x == 0) m_err = 1;
        else if (idx >= 0) begin m_pend_del = 1; m_pend_idx = idx; m_phase = P_UPD; end
        else if (m_q.size() == DEPTH) m_err = 1;
        else begin m_pend_del = 0; m_pend_id = x; m_phase = P_UPD; end
      end
      P_UPD: begin
        if (m_pend_del) m_q.delete(m_pend_idx);
        else m_q.push_back(m_pend_id);
        m_phase = P_ADMIN;
      end
      default: begin
        m_left--;
        if (m_left == 0) m_phase = P_IDLE;
      end
    endcase
  endtask

  function automatic logic [11:0] model_exp();
    logic [4:0] leds;
    case (m_phase)
      P_SETUP: leds = 5'b00000;
      P_IDLE:  leds = 5'b01000;
      P_ADMIN: leds = 5'b01100;
      P_UPD:   leds = 5'b11100;
      P_GRANT: leds = 5'b00110;
      P_DENY:  leds = 5'b10000;
      default: leds = 5'b10001;
    endcase
    return {leds, m_err, (m_phase <= P_ADMIN), (m_q.size() == DEPTH), CNT_W'(m_q.size())};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic cycle(input bit v, input logic [ID_W-1:0] x);
    @(negedge clk);
    id_valid = v;
    id = x;
    @(posedge clk);
    model_step(v, x);
    #1;
    check("model", 16'(dut_vec()), 16'(model_exp()));
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    id_valid = 1'b0;
    #1;
    model_reset();
    check("async_reset", 16'(dut_vec()), 16'(RESET_VEC));
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic bit sel_sig(input int sel);
    if (sel == 0) return unlock;
    if (sel == 1) return red_led;
    return alarm;
  endfunction

  // Counts how many consecutive cycles the selected output stays high,
  // the entering cycle already counted as one.
  task automatic wait_window(input string name, input int sel, input int len,
                             input bit v, input logic [ID_W-1:0] x);
    int n = 1;
    for (int k = 0; k < 200; k++) begin
      cycle(v, x);
      if (sel_sig(sel)) n++;
      else break;
    end
    check(name, 16'(n), 16'(len));
    check({name, "_then_idle"}, 16'({red_led, blue_led, green_led, unlock, alarm}), 16'(5'b01000));
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    bit              v;
    logic [ID_W-1:0] x;
    logic [4:0]      leds;
    bit              e;
    bit              rdy;
    bit              f;
    logic [CNT_W-1:0] cnt;
  } vec_t;

  vec_t vecs[12];
  localparam logic [ID_W-1:0] ADMIN_ID = 32'hA5A5_0001;

  initial begin
    vecs[0]  = '{1, 32'h0,     5'b00000, 1, 1, 0, 0};
    vecs[1]  = '{1, ADMIN_ID,  5'b01000, 0, 1, 0, 0};
    vecs[2]  = '{1, ADMIN_ID,  5'b01100, 0, 1, 0, 0};
    vecs[3]  = '{1, 32'h11,    5'b11100, 0, 0, 0, 0};
    vecs[4]  = '{0, 32'h0,     5'b01100, 0, 1, 0, 1};
    vecs[5]  = '{1, 32'h22,    5'b11100, 0, 0, 0, 1};
    vecs[6]  = '{0, 32'h0,     5'b01100, 0, 1, 0, 2};
    vecs[7]  = '{1, 32'h33,    5'b11100, 0, 0, 0, 2};
    vecs[8]  = '{0, 32'h0,     5'b01100, 0, 1, 0, 3};
    vecs[9]  = '{1, 32'h22,    5'b11100, 0, 0, 0, 3};
    vecs[10] = '{1, 32'h55,    5'b01100, 0, 1, 0, 2};  // offered during DEL: dropped
    vecs[11] = '{1, 32'h0,     5'b01100, 1, 1, 0, 2};

    model_reset();
    do_reset();

    for (int i = 0; i < 12; i++) begin
      cycle(vecs[i].v, vecs[i].x);
      check($sformatf("vec%0d", i), 16'(dut_vec()),
            16'({vecs[i].leds, vecs[i].e, vecs[i].rdy, vecs[i].f, vecs[i].cnt}));
    end
    check("tbl0", 16'(dut.u_table.entries[0]), 16'h0011);
    check("tbl1", 16'(dut.u_table.entries[1]), 16'h0033);

    // fill to DEPTH, then one more is rejected
    for (int k = 0; k < 6; k++) begin
      cycle(1, 32'h44 + 32'(k) * 32'h11);
      cycle(0, 0);
    end
    check("filled", 16'({full, user_count}), 16'({1'b1, CNT_W'(DEPTH)}));
    cycle(1, 32'hAA);
    check("full_reject", 16'(dut_vec()), 16'({5'b01100, 1'b1, 1'b1, 1'b1, CNT_W'(DEPTH)}));
    check("full_state", 16'(state_dbg), 16'(S_ADMIN));

    // user mode grant window
    cycle(1, ADMIN_ID);
    cycle(1, 32'h33);
    wait_window("grant_len", 0, UNLOCK_C, 0, 0);

    // two denials then lockout; valid held high with a known ID during lockout
    cycle(1, 32'hDEAD_0001);
    wait_window("deny1_len", 1, UNLOCK_C, 0, 0);
    cycle(1, 32'hDEAD_0002);
    wait_window("deny2_len", 1, UNLOCK_C, 0, 0);
    cycle(1, 32'hDEAD_0003);
    check("lock_enter", 16'({red_led, alarm}), 16'(2'b11));
    wait_window("lock_len", 2, LOCK_C, 1, 32'h33);

    // a grant between denials clears the fail count
    cycle(1, 32'hBEEF_0001);
    wait_window("deny_a", 1, UNLOCK_C, 0, 0);
    cycle(1, 32'h11);
    wait_window("grant_b", 0, UNLOCK_C, 0, 0);
    cycle(1, 32'hBEEF_0002);
    wait_window("deny_c", 1, UNLOCK_C, 0, 0);
    cycle(1, 32'hBEEF_0003);
    check("no_lockout", 16'({red_led, alarm}), 16'(2'b10));
    wait_window("deny_d", 1, UNLOCK_C, 0, 0);

    // reset in the middle of a grant, then re-enrol
    cycle(1, 32'h11);
    cycle(0, 0);
    cycle(0, 0);
    do_reset();
    cycle(1, 32'h11);
    check("reenrol", 16'(dut_vec()), 16'({5'b01000, 1'b0, 1'b1, 1'b0, CNT_W'(0)}));
    cycle(1, 32'h11);
    check("reenrol_admin", 16'({blue_led, green_led, user_count}), 16'({2'b11, CNT_W'(0)}));

    // randomized run against the reference model
    for (int r = 0; r < 2; r++) begin
      do_reset();
      for (int k = 0; k < 2500; k++) begin
        cycle($urandom_range(0, 3) != 0, 32'($urandom_range(0, 14)));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
